feature_slot_buffer: RTL and testbench



---
 rtl/feature_slot_buffer.sv | 87 ++++++++
 tb/tb_feature_slot_buffer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/feature_slot_buffer.sv
// Width-converting feature slot: wide words land in a simple-dual-port RAM and
// drain as narrow features through a 2-entry prefetch skid on a valid/ready stream.
module feature_slot_buffer #(
  parameter int    WRITE_WIDTH = 64,
  parameter int    READ_WIDTH  = 32,
  parameter int    WRITE_DEPTH = 512,
  parameter int    READ_DEPTH  = 1024,
  parameter string BUFFER_TYPE = "AGGREGATION"
) (
  input  logic                            core_clk,
  input  logic                            rst,
  input  logic                            write_enable,
  input  logic [$clog2(WRITE_DEPTH)-1:0]  write_address,
  input  logic [WRITE_WIDTH-1:0]          write_data,
  input  logic                            flush,
  output logic                            out_feature_valid,
  input  logic                            out_feature_ready,
  output logic [READ_WIDTH-1:0]           out_feature,
  output logic [$clog2(READ_DEPTH):0]     feature_count,
  output logic                            slot_free,
  output logic                            overflow
);
  localparam int RATIO = WRITE_WIDTH / READ_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = $clog2(WRITE_DEPTH);
  localparam int PW    = $clog2(READ_DEPTH);
  localparam int CW    = PW + 1;
  localparam bit XFORM = (BUFFER_TYPE == "TRANSFORMATION");

  if ((WRITE_WIDTH % READ_WIDTH) != 0 || READ_DEPTH != WRITE_DEPTH * RATIO) begin : g_bad_cfg
    $error("feature_slot_buffer: inconsistent width/depth parameters");
  end

  logic [RATIO-1:0][READ_WIDTH-1:0] mem [WRITE_DEPTH];
  logic [RATIO-1:0][READ_WIDTH-1:0] rd_word;
  logic [1:0][READ_WIDTH-1:0]       skid;
  logic [1:0]                       occ;
  logic [PW-1:0]                    rd_ptr;
  logic [AW-1:0]                    wr_ptr, wr_addr, rd_addr;
  logic [LW-1:0]                    lane;
  logic [CW-1:0]                    count;
  logic                             ovf, pop, issue, wr_ok, wr_acc, clr;

  assign clr     = rst | flush;
  assign pop     = (occ != 2'd0) && out_feature_ready;
  // Fetch looks only at registered state, so ready never reaches the RAM address.
  assign issue   = (count > CW'(occ)) && (occ != 2'd2);
  assign rd_addr = AW'(rd_ptr / PW'(RATIO));
  assign lane    = LW'(rd_ptr % PW'(RATIO));
  assign rd_word = mem[rd_addr];
  assign wr_ok   = (int'(count) + RATIO) <= (READ_DEPTH + int'(pop));
  assign wr_acc  = write_enable && wr_ok && !clr;
  assign wr_addr = XFORM ? wr_ptr : write_address;

  always_ff @(posedge core_clk) begin
    if (wr_acc) mem[wr_addr] <= write_data;
  end

  always_ff @(posedge core_clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      occ    <= 2'd0;
      skid   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (issue) rd_ptr <= (rd_ptr == PW'(READ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (wr_acc && XFORM) wr_ptr <= (wr_ptr == AW'(WRITE_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (write_enable && !wr_ok) ovf <= 1'b1;
      count <= count + (wr_acc ? CW'(RATIO) : CW'(0)) - {{(CW-1){1'b0}}, pop};
      occ   <= occ + {1'b0, issue} - {1'b0, pop};
      if (pop) skid[0] <= skid[1];
      // The fetched lane lands in the first slot left free after this cycle's pop.
      if (issue) begin
        if (occ == 2'd0 || (occ == 2'd1 && pop)) skid[0] <= rd_word[lane];
        else                                     skid[1] <= rd_word[lane];
      end
    end
  end

  assign out_feature_valid = (occ != 2'd0);
  assign out_feature       = skid[0];
  assign feature_count     = count;
  assign slot_free         = (count == '0);
  assign overflow          = ovf;
endmodule

// File: tb/tb_feature_slot_buffer.sv
// Scoreboard bench: two slots (address-driven and append mode) get identical traffic
// and are checked each cycle against a queue model of features and their write cycle.
module tb_feature_slot_buffer;
  localparam int WW = 64, RW = 32, WD = 4, RD = 8, RATIO = WW / RW;

  logic          clk = 1'b0;
  logic          rst, we, flush, ready;
  logic [1:0]    waddr_a, waddr_x;
  logic [WW-1:0] wdata;
  logic          vld_a, vld_x, free_a, free_x, ovf_a, ovf_x;
  logic [RW-1:0] data_a, data_x;
  logic [3:0]    cnt_a, cnt_x;

  feature_slot_buffer #(.WRITE_WIDTH(WW), .READ_WIDTH(RW), .WRITE_DEPTH(WD),
    .READ_DEPTH(RD), .BUFFER_TYPE("AGGREGATION")) u_agg (
    .core_clk(clk), .rst(rst), .write_enable(we), .write_address(waddr_a),
    .write_data(wdata), .flush(flush), .out_feature_valid(vld_a),
    .out_feature_ready(ready), .out_feature(data_a), .feature_count(cnt_a),
    .slot_free(free_a), .overflow(ovf_a));

  feature_slot_buffer #(.WRITE_WIDTH(WW), .READ_WIDTH(RW), .WRITE_DEPTH(WD),
    .READ_DEPTH(RD), .BUFFER_TYPE("TRANSFORMATION")) u_xf (
    .core_clk(clk), .rst(rst), .write_enable(we), .write_address(waddr_x),
    .write_data(wdata), .flush(flush), .out_feature_valid(vld_x),
    .out_feature_ready(ready), .out_feature(data_x), .feature_count(cnt_x),
    .slot_free(free_x), .overflow(ovf_x));

  always #5 clk = ~clk;

  typedef struct { logic [RW-1:0] d; int stamp; } feat_t;
  feat_t q[$];
  int    cyc = 0, total = 0, bad = 0, agg_ptr = 0;
  bit    ovf_m = 1'b0, chk_en = 1'b0, just_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // A feature written in cycle t is presented from cycle t+2 onward once it reaches the head.
  always @(negedge clk) begin
    bit            ev;
    logic [RW-1:0] ed;
    feat_t         f;
    ev = (q.size() > 0) && (q[0].stamp + 2 <= cyc);
    ed = ev ? q[0].d : '0;
    if (chk_en) begin
      chk("valid_agg", vld_a, ev);
      chk("valid_xf",  vld_x, ev);
      if (ev) begin
        chk("data_agg", data_a, ed);
        chk("data_xf",  data_x, ed);
      end
      if (just_rst) chk("reset_data", data_a, 0);
      chk("count_agg", cnt_a, q.size());
      chk("count_xf",  cnt_x, q.size());
      chk("free_agg",  free_a, q.size() == 0);
      chk("free_xf",   free_x, q.size() == 0);
      chk("ovf_agg",   ovf_a, ovf_m);
      chk("ovf_xf",    ovf_x, ovf_m);
    end
    just_rst = rst;
    if (rst || flush) begin
      q.delete();
      ovf_m   = 1'b0;
      agg_ptr = 0;
      if (rst) chk_en = 1'b1;
    end else begin
      if (ev && ready) void'(q.pop_front());
      if (we) begin
        if (q.size() + RATIO <= RD) begin
          for (int l = 0; l < RATIO; l++) begin
            f.d     = wdata[l*RW +: RW];
            f.stamp = cyc;
            q.push_back(f);
          end
          agg_ptr = (agg_ptr + 1) % WD;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  end

  task automatic drv(input bit w, input bit r, input logic [WW-1:0] d);
    we      = w;
    ready   = r;
    wdata   = d;
    waddr_a = 2'(agg_ptr);
    waddr_x = 2'($urandom_range(0, WD - 1));
    @(posedge clk); #1;
  endtask

  function automatic logic [WW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; we = 1'b0; ready = 1'b0;
    wdata = '0; waddr_a = '0; waddr_x = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drv(0, 1, '0);
    // single word, lanes drained low then high
    drv(1, 1, 64'h11112222_33334444);
    repeat (5) drv(0, 1, '0);
    // fill with ready low, fifth write must be dropped and flag overflow
    for (int i = 0; i < 5; i++) drv(1, 0, rnd());
    repeat (3) drv(0, 0, '0);
    repeat (10) drv(0, 1, '0);
    flush = 1'b1; drv(0, 1, '0); flush = 1'b0;
    // write every other cycle under sustained ready
    for (int i = 0; i < 20; i++) begin
      drv(1, 1, rnd());
      drv(0, 1, '0);
    end
    repeat (4) drv(0, 1, '0);
    // random traffic with backpressure; pointers wrap many times
    for (int i = 0; i < 700; i++) drv($urandom_range(0, 1), $urandom_range(0, 3) != 0, rnd());
    repeat (12) drv(0, 1, '0);
    ovf_clear: begin
      flush = 1'b1; drv(0, 0, '0); flush = 1'b0;
    end
    // back-to-back writes with draining to exercise the net-of-accept full check
    for (int i = 0; i < 40; i++) drv(1, 1, rnd());
    repeat (10) drv(0, 1, '0);
    // flush with skid full, then a fresh write must appear two cycles later
    drv(1, 0, rnd());
    drv(1, 0, rnd());
    repeat (3) drv(0, 0, '0);
    flush = 1'b1; drv(1, 1, rnd()); flush = 1'b0;
    drv(1, 1, 64'hAAAA5555_0F0F1234);
    repeat (5) drv(0, 1, '0);
    // reset mid-stream leaves nothing behind
    for (int i = 0; i < 3; i++) drv(1, 0, rnd());
    rst = 1'b1; drv(0, 1, '0); rst = 1'b0;
    drv(1, 1, rnd());
    repeat (6) drv(0, 1, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
